// File: rtl/ex_branch_ctrl_pkg.sv
// Shared definitions for the execute-stage branch controller:
// condition codes, controller state encoding and flag bit positions.
package ex_pkg;

    localparam logic [2:0] BR_NEQ = 3'b000;
    localparam logic [2:0] BR_EQ  = 3'b001;
    localparam logic [2:0] BR_GT  = 3'b010;
    localparam logic [2:0] BR_LT  = 3'b011;
    localparam logic [2:0] BR_GTE = 3'b100;
    localparam logic [2:0] BR_LTE = 3'b101;
    localparam logic [2:0] BR_OVF = 3'b110;
    localparam logic [2:0] BR_UNC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } ctrlState_e;

    localparam int F_Z = 2;
    localparam int F_V = 1;
    localparam int F_N = 0;

endpackage

// File: rtl/ex_branch_ctrl_br_cond_eval.sv
// Combinational branch condition evaluation from the {Z,V,N} flag register.
module br_cond_eval
    import ex_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] branchOp,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[F_Z];
    assign v = flags[F_V];
    assign n = flags[F_N];

    always_comb begin
        taken = 1'b0;
        case (branchOp)
            BR_NEQ:  taken = !z;
            BR_EQ:   taken = z;
            BR_GT:   taken = !z && !n;
            BR_LT:   taken = n;
            BR_GTE:  taken = z || !n;
            BR_LTE:  taken = z || n;
            BR_OVF:  taken = v;
            BR_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_ctrl.sv
// Execute-stage sequencing: flag register, branch resolution and redirect,
// post-branch flush sequencing, halt, and saturating branch statistics.
module ex_branch_ctrl
    import ex_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic             alu_zr,
    input  logic             alu_ov,
    input  logic             alu_neg,
    input  logic             z_we,
    input  logic             nv_we,
    input  logic             is_branch,
    input  logic [2:0]       branch_op,
    input  logic [15:0]      br_target,
    input  logic             is_hlt,
    output logic             pc_sel,
    output logic [15:0]      pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             branch_taken,
    output logic             halted,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt,
    output logic [1:0]       dbgState
);

    // The taken cycle is the first flush cycle, so FLUSH covers the remaining
    // FLUSH_CYCLES-1; the counter holds how many FLUSH cycles follow the current one.
    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    ctrlState_e       stateQ, stateD;
    logic [2:0]       cntQ, cntD;
    logic [2:0]       flagsQ;
    logic [15:0]      tgtQ;
    logic [CNT_W-1:0] takenQ, ntakenQ;
    logic             condTaken;
    logic             active;
    logic             qual;
    logic             brTake;
    logic             hltGo;

    br_cond_eval uCond (
        .flags    (flagsQ),
        .branchOp (branch_op),
        .taken    (condTaken)
    );

    assign active = rst_n && ex_valid && (stateQ == ST_IDLE);
    assign qual   = active && !stall;
    assign brTake = active && is_branch && condTaken;
    assign hltGo  = qual && is_hlt && !is_branch;

    always_comb begin
        stateD       = stateQ;
        cntD         = cntQ;
        pc_sel       = 1'b0;
        pc_target    = br_target;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        branch_taken = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (brTake) begin
                    pc_sel       = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    branch_taken = 1'b1;
                    if (!stall && FLUSH_CYCLES > 1) begin
                        stateD = ST_FLUSH;
                        cntD   = FLUSH_LOAD;
                    end
                end else if (hltGo) begin
                    stateD = ST_HALT;
                end
            end
            ST_FLUSH: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (!stall) begin
                    if (cntQ == 3'd0) begin
                        stateD = ST_IDLE;
                    end else begin
                        cntD = cntQ - 3'd1;
                    end
                end
            end
            ST_HALT: begin
                pc_sel      = 1'b1;
                pc_target   = tgtQ;
                flush_if_id = 1'b1;
            end
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= ST_IDLE;
            cntQ    <= 3'd0;
            flagsQ  <= 3'b000;
            tgtQ    <= 16'h0000;
            takenQ  <= '0;
            ntakenQ <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (qual && z_we) begin
                flagsQ[F_Z] <= alu_zr;
            end
            if (qual && nv_we) begin
                flagsQ[F_N] <= alu_neg;
                flagsQ[F_V] <= alu_ov;
            end
            if (hltGo) begin
                tgtQ <= br_target;
            end
            if (qual && is_branch) begin
                if (condTaken) begin
                    if (takenQ != '1) takenQ <= takenQ + 1'b1;
                end else begin
                    if (ntakenQ != '1) ntakenQ <= ntakenQ + 1'b1;
                end
            end
        end
    end

    assign halted     = (stateQ == ST_HALT);
    assign flags      = flagsQ;
    assign taken_cnt  = takenQ;
    assign ntaken_cnt = ntakenQ;
    assign dbgState   = stateQ;

endmodule

// File: tb/tb_ex_branch_ctrl.sv
// Self-checking bench for ex_branch_ctrl: truth-table sweep, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_ex_branch_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;
    localparam int SAT_W        = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, stall, alu_zr, alu_ov, alu_neg, z_we, nv_we;
    logic        is_branch, is_hlt;
    logic [2:0]  branch_op;
    logic [15:0] br_target;

    logic              pc_sel, flush_if_id, flush_id_ex, branch_taken, halted;
    logic [15:0]       pc_target;
    logic [2:0]        flags;
    logic [CNT_W-1:0]  taken_cnt, ntaken_cnt;
    logic [1:0]        dbgState;

    logic              satPcSel, satFlushIfId, satFlushIdEx, satBranchTaken, satHalted;
    logic [15:0]       satPcTarget;
    logic [2:0]        satFlags;
    logic [SAT_W-1:0]  satTaken, satNtaken;
    logic [1:0]        satDbgState;

    ex_branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall),
        .alu_zr(alu_zr), .alu_ov(alu_ov), .alu_neg(alu_neg), .z_we(z_we), .nv_we(nv_we),
        .is_branch(is_branch), .branch_op(branch_op), .br_target(br_target), .is_hlt(is_hlt),
        .pc_sel(pc_sel), .pc_target(pc_target), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .branch_taken(branch_taken), .halted(halted),
        .flags(flags), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt), .dbgState(dbgState)
    );

    ex_branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(SAT_W)) dutSat (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall),
        .alu_zr(alu_zr), .alu_ov(alu_ov), .alu_neg(alu_neg), .z_we(z_we), .nv_we(nv_we),
        .is_branch(is_branch), .branch_op(branch_op), .br_target(br_target), .is_hlt(is_hlt),
        .pc_sel(satPcSel), .pc_target(satPcTarget), .flush_if_id(satFlushIfId),
        .flush_id_ex(satFlushIdEx), .branch_taken(satBranchTaken), .halted(satHalted),
        .flags(satFlags), .taken_cnt(satTaken), .ntaken_cnt(satNtaken), .dbgState(satDbgState)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          mZ, mV, mN, mHalt;
    int          mFlushLeft;
    logic [15:0] mTgt;
    int          mTaken, mNtaken;

    typedef struct {
        logic [2:0] flagsIn;
        logic [2:0] op;
        logic       expTaken;
    } vec_t;

    vec_t       vecs [64];
    logic [7:0] masks [8];

    function automatic bit condOf(input logic [2:0] op, input bit z, input bit v, input bit n);
        case (op)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        bit idle;
        bit tk;
        int satT, satN;
        idle = !mHalt && (mFlushLeft == 0);
        tk   = idle && rst_n && ex_valid && is_branch && condOf(branch_op, mZ, mV, mN);
        satT = (mTaken > 15) ? 15 : mTaken;
        satN = (mNtaken > 15) ? 15 : mNtaken;
        chk({tag, "/pc_sel"},       32'(pc_sel),       32'(mHalt || tk));
        chk({tag, "/pc_target"},    32'(pc_target),    32'(mHalt ? mTgt : br_target));
        chk({tag, "/flush_if_id"},  32'(flush_if_id),  32'(mHalt || mFlushLeft > 0 || tk));
        chk({tag, "/flush_id_ex"},  32'(flush_id_ex),  32'(mFlushLeft > 0 || tk));
        chk({tag, "/branch_taken"}, 32'(branch_taken), 32'(tk));
        chk({tag, "/halted"},       32'(halted),       32'(mHalt));
        chk({tag, "/flags"},        32'(flags),        32'({mZ, mV, mN}));
        chk({tag, "/taken_cnt"},    32'(taken_cnt),    32'(mTaken));
        chk({tag, "/ntaken_cnt"},   32'(ntaken_cnt),   32'(mNtaken));
        chk({tag, "/sat_taken"},    32'(satTaken),     32'(satT));
        chk({tag, "/sat_ntaken"},   32'(satNtaken),    32'(satN));
    endtask

    task automatic modelEdge();
        bit c;
        if (!rst_n || stall || mHalt) return;
        if (mFlushLeft > 0) begin
            mFlushLeft--;
            return;
        end
        if (!ex_valid) return;
        c = condOf(branch_op, mZ, mV, mN);
        if (z_we) mZ = alu_zr;
        if (nv_we) begin
            mV = alu_ov;
            mN = alu_neg;
        end
        if (is_branch) begin
            if (c) begin
                mTaken++;
                mFlushLeft = FLUSH_CYCLES - 1;
            end else begin
                mNtaken++;
            end
        end else if (is_hlt) begin
            mHalt = 1'b1;
            mTgt  = br_target;
        end
    endtask

    task automatic modelReset();
        mZ = 0; mV = 0; mN = 0; mHalt = 0;
        mFlushLeft = 0; mTgt = 16'h0; mTaken = 0; mNtaken = 0;
    endtask

    // called just after a falling edge with inputs already driven
    task automatic tick(input string tag);
        #1;
        checkAll(tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic idleIn();
        ex_valid = 0; stall = 0; alu_zr = 0; alu_ov = 0; alu_neg = 0;
        z_we = 0; nv_we = 0; is_branch = 0; is_hlt = 0; branch_op = 3'd0; br_target = 16'h0;
    endtask

    task automatic aluOp(input bit z, input bit v, input bit n);
        idleIn();
        ex_valid = 1; z_we = 1; nv_we = 1; alu_zr = z; alu_ov = v; alu_neg = n;
    endtask

    task automatic branchIn(input logic [2:0] op, input logic [15:0] tgt);
        idleIn();
        ex_valid = 1; is_branch = 1; branch_op = op; br_target = tgt;
    endtask

    task automatic drain();
        idleIn();
        for (int k = 0; k < 10 && mFlushLeft > 0; k++) tick("drain");
    endtask

    task automatic doReset();
        rst_n = 0;
        idleIn();
        modelReset();
        #1;
        checkAll("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic randomIn();
        idleIn();
        ex_valid  = ($urandom_range(0, 3) != 0);
        stall     = ($urandom_range(0, 3) == 0);
        z_we      = $urandom_range(0, 1);
        nv_we     = $urandom_range(0, 1);
        alu_zr    = $urandom_range(0, 1);
        alu_ov    = $urandom_range(0, 1);
        alu_neg   = $urandom_range(0, 1);
        is_branch = ($urandom_range(0, 2) == 0);
        is_hlt    = ($urandom_range(0, 49) == 0);
        branch_op = 3'($urandom_range(0, 7));
        br_target = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        logic [15:0] t4Taken;
        int haltCycles;

        masks = '{8'h0F, 8'hF0, 8'h05, 8'hAA, 8'hF5, 8'hFA, 8'hCC, 8'hFF};
        for (int op = 0; op < 8; op++) begin
            for (int f = 0; f < 8; f++) begin
                vecs[op*8+f] = '{3'(f), 3'(op), masks[op][f]};
            end
        end

        idleIn();
        rst_n = 0;
        @(negedge clk);
        doReset();

        // flag write from one ALU op
        aluOp(1, 1, 0);
        tick("t1_alu");
        idleIn();
        #1 chk("t1_flags", 32'(flags), 32'h6);
        tick("t1_after");

        // NEQ taken with redirect and two-cycle flush
        aluOp(0, 0, 0);
        tick("t2_clrz");
        branchIn(3'd0, 16'h0040);
        #1;
        chk("t2_c0_pc_sel", 32'(pc_sel), 32'h1);
        chk("t2_c0_pc_target", 32'(pc_target), 32'h0040);
        chk("t2_c0_taken", 32'(branch_taken), 32'h1);
        chk("t2_c0_flush_if_id", 32'(flush_if_id), 32'h1);
        chk("t2_c0_flush_id_ex", 32'(flush_id_ex), 32'h1);
        tick("t2_c0");
        branchIn(3'd7, 16'h0099);
        #1;
        chk("t2_c1_pc_sel", 32'(pc_sel), 32'h0);
        chk("t2_c1_flush_if_id", 32'(flush_if_id), 32'h1);
        chk("t2_c1_flush_id_ex", 32'(flush_id_ex), 32'h1);
        chk("t2_c1_taken", 32'(branch_taken), 32'h0);
        tick("t2_c1");
        idleIn();
        #1;
        chk("t2_c2_flush_if_id", 32'(flush_if_id), 32'h0);
        chk("t2_c2_flush_id_ex", 32'(flush_id_ex), 32'h0);
        chk("t2_taken_cnt", 32'(taken_cnt), 32'h1);
        tick("t2_c2");

        // full condition table sweep from a clean reset
        doReset();
        for (int i = 0; i < 64; i++) begin
            aluOp(vecs[i].flagsIn[2], vecs[i].flagsIn[1], vecs[i].flagsIn[0]);
            tick("t3_alu");
            branchIn(vecs[i].op, 16'($urandom_range(0, 65535)));
            #1 chk($sformatf("t3_op%0d_f%0d", vecs[i].op, vecs[i].flagsIn),
                   32'(branch_taken), 32'(vecs[i].expTaken));
            tick("t3_br");
            drain();
        end
        chk("t3_sum", 32'(taken_cnt) + 32'(ntaken_cnt), 32'd64);
        chk("t3_taken_total", 32'(taken_cnt), 32'd38);

        // taken resolution held off by stall
        t4Taken = 16'(mTaken + 1);
        branchIn(3'd7, 16'h1234);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_stall_taken", 32'(branch_taken), 32'h1);
            chk("t4_stall_pc_sel", 32'(pc_sel), 32'h1);
            tick("t4_stall");
        end
        stall = 0;
        tick("t4_release");
        idleIn();
        #1 chk("t4_flush1", 32'(flush_if_id), 32'h1);
        tick("t4_f1");
        #1 chk("t4_idle", 32'(flush_if_id), 32'h0);
        chk("t4_taken_cnt", 32'(taken_cnt), 32'(t4Taken));
        tick("t4_done");

        // halt, then asynchronous reset out of it
        idleIn();
        ex_valid = 1; is_hlt = 1; br_target = 16'hBEEF;
        #1 chk("t5_pre_halt", 32'(halted), 32'h0);
        tick("t5_hlt");
        for (int k = 0; k < 10; k++) begin
            randomIn();
            #1;
            chk("t5_halted", 32'(halted), 32'h1);
            chk("t5_pc_target", 32'(pc_target), 32'hBEEF);
            tick("t5_hold");
        end
        #2 rst_n = 0;
        #1;
        chk("t5_async_halted", 32'(halted), 32'h0);
        chk("t5_async_pc_sel", 32'(pc_sel), 32'h0);
        chk("t5_async_flush", 32'(flush_if_id), 32'h0);
        modelReset();
        @(negedge clk);
        doReset();

        // saturation of the narrow counter
        for (int k = 0; k < 20; k++) begin
            branchIn(3'd7, 16'(k));
            tick("t6_br");
            drain();
        end
        #1;
        chk("t6_sat_taken", 32'(satTaken), 32'hF);
        chk("t6_wide_taken", 32'(taken_cnt), 32'd20);

        // randomized traffic against the model
        haltCycles = 0;
        for (int k = 0; k < 600; k++) begin
            randomIn();
            tick("rand");
            if (mHalt) haltCycles++;
            if (haltCycles > 4) begin
                haltCycles = 0;
                doReset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
